switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-output-port wormhole allocator for the chiplet switch crossbar.
- Arbitrates input buffers competing for each outport using round-robin.
- Locks the outport to the winning buffer until that buffer's tail flit passes.
- Tracks downstream credits per outport/VC; only grants a flit when a credit is available. Drives crossbar select, data_ready_out and packet_sent.

Parameters:
- NUM_BUFFERS, 4, input buffers (requesters)
- NUM_OUTPORTS, 4, output ports (resources)
- NUM_VCS, 2, virtual channels per link
- CREDIT_DEPTH, 8, downstream buffer slots per VC; credit counter reset value

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous active-high reset
- req  input  NUM_BUFFERS  buffer has a flit at head
- req_outport  input  NUM_BUFFERS x clog2(NUM_OUTPORTS)  routed outport of head flit
- req_vc  input  NUM_BUFFERS x clog2(NUM_VCS)  VC of head flit
- req_tail  input  NUM_BUFFERS  head flit is last of its packet
- credit_granted  input  NUM_OUTPORTS x NUM_VCS  one-cycle credit-return pulses
- grant  output  NUM_BUFFERS  pop head flit this cycle
- outport_sel  output  NUM_OUTPORTS x clog2(NUM_BUFFERS)  crossbar source select
- data_ready_out  output  NUM_OUTPORTS  flit valid on outport this cycle
- packet_sent  output  NUM_OUTPORTS  tail flit left outport this cycle

Behaviour:
- Reset values:
  - All outport FSMs IDLE; owners 0; RR pointers = NUM_BUFFERS-1.
  - Credits = CREDIT_DEPTH; grant, data_ready_out, packet_sent = 0; outport_sel = 0.
- Per-outport FSM:
  - IDLE:
    - Candidates are buffers with req=1, req_outport=o and credit[o][req_vc]>0.
    - Pick the first candidate scanning from rr_ptr+1 with wrap.
    - Register owner and owner_vc; next state LOCKED. No grant in the IDLE cycle.
  - LOCKED:
    - grant[owner] = req[owner] && credit[o][owner_vc]>0.
    - data_ready_out[o] = that grant; outport_sel[o] = owner (held whenever LOCKED).
    - On grant with req_tail[owner]=1: packet_sent[o]=1 same cycle, rr_ptr<=owner, next IDLE.
- Latency: head flit presented in cycle N is granted at earliest in N+1. Body/tail flits stream one per cycle while credits last.
- Single-flit packet (head is tail): one LOCKED cycle, then IDLE. The next packet to the same outport is granted after 1 idle cycle (arbitration bubble).
- Owner deasserts req mid-packet: stay LOCKED, no grant, no timeout.
- Credits, per (o,v):
  - next = cur - dec + inc, where dec = grant on (o,v) and inc = credit_granted[o][v].
  - Simultaneous dec and inc leaves the value unchanged.
  - At 0: no grant and the FSM holds.
  - Increment at CREDIT_DEPTH saturates (stays CREDIT_DEPTH).
  - Width clog2(CREDIT_DEPTH+1).
- Exclusivity: a buffer requests exactly one outport, so at most one outport grants a given buffer. grant is the OR across outports of owner matches.
- Outports are independent; all may be LOCKED simultaneously.
- Reset mid-packet: immediate return to reset values; in-flight packets are abandoned by the allocator. Upstream/downstream reset together.

Optional Feature:
- Macro: SWITCH_ALLOC_CREDIT_CHECK_EN.
- Defined:
  - Adds output credit_err, 1 bit, reset 0, sticky until RST.
  - Sets when credit_granted arrives at CREDIT_DEPTH (overflow).
  - Also sets when req_vc[owner] differs from owner_vc during LOCKED with req=1 (VC change mid-packet).
  - Saturation behaviour unchanged.
- Undefined: no port, no checking logic.

Decomposition:
- chiplet_types_pkg gets:
  - alloc_state_t enum {IDLE, LOCKED}
  - credit_cnt_t, sized from CREDIT_DEPTH
  - port-index typedefs derived from NUM_OUTPORTS/NUM_BUFFERS
- Natural sub-module: rr_arbiter (NUM_BUFFERS-wide request vector + pointer in, one-hot grant + index out), instantiated once per outport.

Test Plan:
- Reset → all credits 8, grant=0, data_ready_out=0. Buffer 0 sends 3-flit packet to outport 1, VC 0 → grants in cycles N+1..N+3, packet_sent[1] in N+3, credit[1][0]=5.
- Buffers 0,1,2 each send single-flit packets to outport 2 continuously → winners rotate 0,1,2,0 with one IDLE bubble between grants.
- Buffer 3 sends 10-flit packet to outport 0, VC 1, no credit returns → 8 grants then stall with LOCKED held. Pulse credit_granted[0][1] twice → remaining 2 flits granted, packet_sent on the second.
- Credit at 0; same-cycle return and owner request → grant asserts, counter stays 0. Credit at 8 with extra return pulse → stays 8; credit_err=1 only when SWITCH_ALLOC_CREDIT_CHECK_EN is defined.
- Buffer 1 to outport 0 and buffer 2 to outport 3, concurrent → both granted every cycle, independent outport_sel values 1 and 2.
- Assert RST mid-packet (after 2 of 4 flits) → next cycle FSMs IDLE, credits 8, no grant. Re-presented head is granted one cycle after arbitration.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet switch: allocator states, index and credit
// widths, and the per-VC credit update rule.
package chiplet_types_pkg;

  localparam int NUM_BUFFERS  = 4;
  localparam int NUM_OUTPORTS = 4;
  localparam int NUM_VCS      = 2;
  localparam int CREDIT_DEPTH = 8;

  localparam int BUF_W = $clog2(NUM_BUFFERS);
  localparam int OP_W  = $clog2(NUM_OUTPORTS);
  localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } alloc_state_t;

  typedef logic [CNT_W-1:0] credit_cnt_t;
  typedef logic [BUF_W-1:0] buf_idx_t;
  typedef logic [OP_W-1:0]  port_idx_t;
  typedef logic [VC_W-1:0]  vc_idx_t;

  localparam credit_cnt_t CREDIT_MAX = credit_cnt_t'(CREDIT_DEPTH);

  // A return pulse at full depth is dropped so the counter saturates.
  function automatic credit_cnt_t cred_next(
    input credit_cnt_t cur,
    input logic        dec,
    input logic        inc
  );
    unique case ({dec, inc})
      2'b10:   cred_next = cur - credit_cnt_t'(1);
      2'b01:   cred_next = (cur == CREDIT_MAX) ? cur : cur + credit_cnt_t'(1);
      default: cred_next = cur;
    endcase
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: first request found scanning upward from i_ptr+1,
// wrapping at N. Returns one-hot grant, its index, and a valid flag.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  int w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int i = 1; i <= N; i++) begin
      w_j = (int'(i_ptr) + i) % N;
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = W'(w_j);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-outport wormhole allocator with round-robin arbitration and per-VC
// downstream credit tracking. Optional credit_err via SWITCH_ALLOC_CREDIT_CHECK_EN.
module switch_allocator
  import chiplet_types_pkg::*;
(
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_BUFFERS-1:0]               req,
  input  logic [NUM_BUFFERS-1:0][OP_W-1:0]     req_outport,
  input  logic [NUM_BUFFERS-1:0][VC_W-1:0]     req_vc,
  input  logic [NUM_BUFFERS-1:0]               req_tail,
  input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] credit_granted,
  output logic [NUM_BUFFERS-1:0]               grant,
  output logic [NUM_OUTPORTS-1:0][BUF_W-1:0]   outport_sel,
  output logic [NUM_OUTPORTS-1:0]              data_ready_out,
  output logic [NUM_OUTPORTS-1:0]              packet_sent
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
  ,
  output logic                                 credit_err
`endif
);

  alloc_state_t r_state     [NUM_OUTPORTS];
  alloc_state_t w_state_nxt [NUM_OUTPORTS];
  buf_idx_t     r_owner     [NUM_OUTPORTS];
  vc_idx_t      r_owner_vc  [NUM_OUTPORTS];
  buf_idx_t     r_rr        [NUM_OUTPORTS];
  credit_cnt_t  r_cred      [NUM_OUTPORTS][NUM_VCS];

  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] w_cand;
  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] w_arb_gnt;
  logic [NUM_OUTPORTS-1:0][BUF_W-1:0]       w_arb_idx;
  logic [NUM_OUTPORTS-1:0]                  w_arb_vld;
  logic [NUM_OUTPORTS-1:0][VC_W-1:0]        w_win_vc;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]     w_dec;

  always_comb begin
    w_cand = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        w_cand[o][b] = req[b]
                    && (req_outport[b] == port_idx_t'(o))
                    && (r_cred[o][req_vc[b]] != '0);
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
    rr_arbiter #(
      .N (NUM_BUFFERS),
      .W (BUF_W)
    ) u_arb (
      .i_req   (w_cand[o]),
      .i_ptr   (r_rr[o]),
      .o_gnt   (w_arb_gnt[o]),
      .o_idx   (w_arb_idx[o]),
      .o_valid (w_arb_vld[o])
    );
  end

  always_comb begin
    w_win_vc = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int b = 0; b < NUM_BUFFERS; b++) begin
        if (w_arb_gnt[o][b]) w_win_vc[o] = req_vc[b];
      end
    end
  end

  // A return pulse arriving with an empty counter is forwarded as a credit.
  always_comb begin
    grant          = '0;
    data_ready_out = '0;
    packet_sent    = '0;
    outport_sel    = '0;
    w_dec          = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      unique case (r_state[o])
        IDLE: begin
          if (w_arb_vld[o]) w_state_nxt[o] = LOCKED;
        end
        LOCKED: begin
          outport_sel[o] = r_owner[o];
          if (req[r_owner[o]]
              && ((r_cred[o][r_owner_vc[o]] != '0)
                  || credit_granted[o][r_owner_vc[o]])) begin
            grant[r_owner[o]]        = 1'b1;
            data_ready_out[o]        = 1'b1;
            w_dec[o][r_owner_vc[o]]  = 1'b1;
            if (req_tail[r_owner[o]]) begin
              packet_sent[o] = 1'b1;
              w_state_nxt[o] = IDLE;
            end
          end
        end
        default: w_state_nxt[o] = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        r_state[o]    <= IDLE;
        r_owner[o]    <= '0;
        r_owner_vc[o] <= '0;
        r_rr[o]       <= buf_idx_t'(NUM_BUFFERS - 1);
        for (int v = 0; v < NUM_VCS; v++) begin
          r_cred[o][v] <= CREDIT_MAX;
        end
      end
    end else begin
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        if ((r_state[o] == IDLE) && w_arb_vld[o]) begin
          r_owner[o]    <= w_arb_idx[o];
          r_owner_vc[o] <= w_win_vc[o];
        end
        if (packet_sent[o]) r_rr[o] <= r_owner[o];
        for (int v = 0; v < NUM_VCS; v++) begin
          r_cred[o][v] <= cred_next(r_cred[o][v], w_dec[o][v],
                                    credit_granted[o][v]);
        end
      end
    end
  end

`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
  logic w_ovf;
  logic w_vc_chg;

  always_comb begin
    w_ovf    = 1'b0;
    w_vc_chg = 1'b0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (credit_granted[o][v] && !w_dec[o][v]
            && (r_cred[o][v] == CREDIT_MAX)) w_ovf = 1'b1;
      end
      if ((r_state[o] == LOCKED) && req[r_owner[o]]
          && (req_vc[r_owner[o]] != r_owner_vc[o])) w_vc_chg = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   credit_err <= 1'b0;
    else if (w_ovf || w_vc_chg) credit_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: scripted per-cycle stimulus pushes
// expected outputs; a negedge monitor captures DUT outputs for comparison.
module tb_switch_allocator;
  import chiplet_types_pkg::*;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic [3:0] p;
    logic [7:0] s;
  } snap_t;

  logic                                 CLK;
  logic                                 RST;
  logic [NUM_BUFFERS-1:0]               req;
  logic [NUM_BUFFERS-1:0][OP_W-1:0]     req_outport;
  logic [NUM_BUFFERS-1:0][VC_W-1:0]     req_vc;
  logic [NUM_BUFFERS-1:0]               req_tail;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] credit_granted;
  logic [NUM_BUFFERS-1:0]               grant;
  logic [NUM_OUTPORTS-1:0][BUF_W-1:0]   outport_sel;
  logic [NUM_OUTPORTS-1:0]              data_ready_out;
  logic [NUM_OUTPORTS-1:0]              packet_sent;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
  logic                                 credit_err;
`endif

  int    checks = 0;
  int    errors = 0;
  logic  cap_en = 1'b0;
  snap_t exp_q[$];
  snap_t obs_q[$];

  switch_allocator dut (
    .CLK            (CLK),
    .RST            (RST),
    .req            (req),
    .req_outport    (req_outport),
    .req_vc         (req_vc),
    .req_tail       (req_tail),
    .credit_granted (credit_granted),
    .grant          (grant),
    .outport_sel    (outport_sel),
    .data_ready_out (data_ready_out),
    .packet_sent    (packet_sent)
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    ,
    .credit_err     (credit_err)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(negedge CLK) begin
    if (cap_en)
      obs_q.push_back(snap_t'({grant, data_ready_out, packet_sent, outport_sel}));
  end

  function automatic logic [7:0] sv(input int o, input int b);
    sv = '0;
    sv[o*2 +: 2] = 2'(b);
  endfunction

  task automatic set_buf(input int b, input logic r, input int op,
                         input logic v, input logic t);
    req[b]         = r;
    req_outport[b] = 2'(op);
    req_vc[b]      = v;
    req_tail[b]    = t;
  endtask

  task automatic clr();
    req            = '0;
    req_outport    = '0;
    req_vc         = '0;
    req_tail       = '0;
    credit_granted = '0;
  endtask

  task automatic step(input logic [3:0] g, input logic [3:0] d,
                      input logic [3:0] p, input logic [7:0] s);
    exp_q.push_back('{g: g, d: d, p: p, s: s});
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    snap_t e, a;
    int n = 0;
    RST = 1'b1;
    clr();
    @(posedge CLK);
    #1;
    cap_en = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    RST = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    cap_en = 1'b0;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    checks++;
    if (credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_credit_err got %b want 0", credit_err);
    end
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL reset cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_basic();
    snap_t e, a;
    int n = 0;
    cap_en = 1'b1;
    set_buf(0, 1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(4'b0001, 4'b0010, 0, sv(1, 0));
    step(4'b0001, 4'b0010, 0, sv(1, 0));
    req_tail[0] = 1'b1;
    step(4'b0001, 4'b0010, 4'b0010, sv(1, 0));
    set_buf(0, 0, 0, 0, 0);
    set_buf(2, 1, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (5) step(4'b0100, 4'b0010, 0, sv(1, 2));
    step(0, 0, 0, sv(1, 2));
    credit_granted[1][0] = 1'b1;
    step(4'b0100, 4'b0010, 0, sv(1, 2));
    credit_granted[1][0] = 1'b0;
    step(0, 0, 0, sv(1, 2));
    credit_granted[1][0] = 1'b1;
    req_tail[2] = 1'b1;
    step(4'b0100, 4'b0010, 4'b0010, sv(1, 2));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL basic cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_rotate();
    snap_t e, a;
    int n = 0;
    cap_en = 1'b1;
    for (int b = 0; b < 3; b++) set_buf(b, 1, 2, 0, 1);
    step(0, 0, 0, 0);
    step(4'b0001, 4'b0100, 4'b0100, sv(2, 0));
    step(0, 0, 0, 0);
    step(4'b0010, 4'b0100, 4'b0100, sv(2, 1));
    step(0, 0, 0, 0);
    step(4'b0100, 4'b0100, 4'b0100, sv(2, 2));
    step(0, 0, 0, 0);
    step(4'b0001, 4'b0100, 4'b0100, sv(2, 0));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rotate_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rotate cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_long_stall();
    snap_t e, a;
    int n = 0;
    cap_en = 1'b1;
    set_buf(3, 1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (8) step(4'b1000, 4'b0001, 0, sv(0, 3));
    repeat (2) step(0, 0, 0, sv(0, 3));
    credit_granted[0][1] = 1'b1;
    step(4'b1000, 4'b0001, 0, sv(0, 3));
    credit_granted[0][1] = 1'b0;
    step(0, 0, 0, sv(0, 3));
    credit_granted[0][1] = 1'b1;
    req_tail[3] = 1'b1;
    step(4'b1000, 4'b0001, 4'b0001, sv(0, 3));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL long_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL long cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_credit_sat();
    snap_t e, a;
    int n = 0;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    checks++;
    if (credit_err !== 1'b0) begin
      errors++;
      $display("FAIL sat_err_pre got %b want 0", credit_err);
    end
`endif
    cap_en = 1'b1;
    credit_granted[0][1] = 1'b1;
    repeat (9) step(0, 0, 0, 0);
    credit_granted[0][1] = 1'b0;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    checks++;
    if (credit_err !== 1'b1) begin
      errors++;
      $display("FAIL sat_err_post got %b want 1", credit_err);
    end
`endif
    set_buf(3, 1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (8) step(4'b1000, 4'b0001, 0, sv(0, 3));
    step(0, 0, 0, sv(0, 3));
    credit_granted[0][1] = 1'b1;
    req_tail[3] = 1'b1;
    step(4'b1000, 4'b0001, 4'b0001, sv(0, 3));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sat_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sat cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_concurrent();
    snap_t e, a;
    int n = 0;
    cap_en = 1'b1;
    set_buf(1, 1, 0, 0, 0);
    set_buf(2, 1, 3, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(4'b0110, 4'b1001, 0, sv(0, 1) | sv(3, 2));
    req_tail[1] = 1'b1;
    req_tail[2] = 1'b1;
    step(4'b0110, 4'b1001, 4'b1001, sv(0, 1) | sv(3, 2));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL conc_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL conc cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    snap_t e, a;
    int n = 0;
    cap_en = 1'b1;
    set_buf(3, 1, 2, 1, 0);
    step(0, 0, 0, 0);
    repeat (2) step(4'b1000, 4'b0100, 0, sv(2, 3));
    RST = 1'b1;
    step(0, 0, 0, 0);
    RST = 1'b0;
`ifdef SWITCH_ALLOC_CREDIT_CHECK_EN
    checks++;
    if (credit_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_err got %b want 0", credit_err);
    end
`endif
    step(0, 0, 0, 0);
    repeat (8) step(4'b1000, 4'b0100, 0, sv(2, 3));
    step(0, 0, 0, sv(2, 3));
    credit_granted[2][1] = 1'b1;
    req_tail[3] = 1'b1;
    step(4'b1000, 4'b0100, 4'b0100, sv(2, 3));
    clr();
    step(0, 0, 0, 0);
    cap_en = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      a = obs_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL mid cyc%0d got %h want %h", n, a, e);
      end
      n++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    RST = 1'b1;
    clr();
    test_reset();
    test_basic();
    test_rotate();
    test_long_stall();
    test_credit_sat();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
